// File: rtl/sm4_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sm4_sbox_sched (with helper sbox_replace)
//  Brief    : Shared SM4 S-box scheduler. Arbitrates between the round
//             datapath (requester 0) and key expansion (requester 1), then
//             applies tau to the granted word by pushing its four bytes
//             through a single S-box, one byte per cycle.
//  Options  : SM4_SBOX_SCHED_RR_EN defined   -> round-robin on contention
//             SM4_SBOX_SCHED_RR_EN undefined -> requester 1 wins contention
//  Revision : 1.0  initial release
// ============================================================================

// Single SM4 S-box lookup, purely combinational.
module sbox_replace (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row r holds S(16*r) .. S(16*r+15); element 0 sits in the top byte.
    localparam logic [0:255][7:0] c_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign o_byte = c_SBOX[i_byte];

endmodule

module sm4_sbox_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SUB  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_sreg;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic        r_busy;

    logic        w_idle;
    logic        w_tie_grant;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_word;
    logic [7:0]  w_sbox_in;
    logic [7:0]  w_sbox_out;

`ifdef SM4_SBOX_SCHED_RR_EN
    // Requester granted at the most recent accept; starts at 1 so that
    // requester 0 wins the first contention after reset.
    logic        r_last_grant;
    assign w_tie_grant = ~r_last_grant;
`else
    // Key expansion always wins a tie.
    assign w_tie_grant = 1'b1;
`endif

    assign w_idle = (r_state == c_ST_IDLE);

    // Pick the requester to serve; a lone valid always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = w_tie_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid &&  w_grant;
    assign w_accept   = req0_ready || req1_ready;
    assign w_word     = w_grant ? req1_data : req0_data;

    // Parking the S-box input at zero outside SUB keeps it from toggling.
    assign w_sbox_in = (r_state == c_ST_SUB) ? r_sreg[31:24] : 8'h00;

    sbox_replace u_sbox (
        .i_byte (w_sbox_in),
        .o_byte (w_sbox_out)
    );

    // Scheduler FSM: accept in IDLE, rotate-and-substitute four bytes in SUB,
    // hold the result in DONE until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 2'd0;
            r_sreg      <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SM4_SBOX_SCHED_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_sreg   <= w_word;
                        r_rsp_id <= w_grant;
                        r_cnt    <= 2'd0;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_SUB;
`ifdef SM4_SBOX_SCHED_RR_EN
                        r_last_grant <= w_grant;
`endif
                    end
                end
                c_ST_SUB: begin
                    // After four rotations every substituted byte is back
                    // in its original lane.
                    r_sreg <= {r_sreg[23:0], w_sbox_out};
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_sreg;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sm4_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm4_sbox_sched
//  Brief    : Self-checking bench for sm4_sbox_sched: vector table, response
//             scoreboard, and hand sequences for stall, contention and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm4_sbox_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic        busy;

    sm4_sbox_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden SM4 S-box, one 16-byte row per entry.
    logic [127:0] sb_rows [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = sb_rows[b[7:4]];
        return row[8*(15 - int'(b[3:0])) +: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox(w[8*j +: 8]);
        return r;
    endfunction

    typedef struct {
        bit          id;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          acc;
    } exp_t;

    vec_t vt [67];
    exp_t q [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;
    bit   lg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: latency on the rising rsp_valid, data/id on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && !prev_valid) begin
                if (q.size() == 0) check("unexpected_rsp", 64'(rsp_data), 64'hffff_ffff_ffff_ffff);
                else               check("latency", 64'(cyc - q[0].acc), 64'd4);
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                check("rsp_data", 64'(rsp_data), 64'(q[0].data));
                check("rsp_id", 64'(rsp_id), 64'(q[0].id));
                void'(q.pop_front());
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic send(input bit id, input logic [31:0] d, input logic [31:0] e);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        else begin
            q.push_back('{id: id, data: e, acc: cyc + 1});
            lg = id;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        lg = 1'b1;
    endtask

    initial begin
        int   prev_acc;
        bit   exp_win;
        bit   got;
        logic [31:0] d0, d1, w;

        // Vector table: spec vectors with hand-derived results, then a sweep.
        vt[0] = '{id: 1'b0, data: 32'h00010203, exp: 32'hd690e9fe};
        vt[1] = '{id: 1'b1, data: 32'hffab0010, exp: 32'h48abd62b};
        vt[2] = '{id: 1'b0, data: 32'h00000000, exp: 32'hd6d6d6d6};
        for (int k = 0; k < 64; k++) begin
            for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(4*k + ((j + k) % 4));
            vt[3 + k] = '{id: 1'(k % 2), data: w, exp: tau(w)};
        end

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 32'd0; req1_data = 32'd0; rsp_ready = 1'b0; lg = 1'b1;

        // Reset values and ready-follows-valid while held in reset.
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        req0_valid = 1'b1; #1;
        check("rst_ready_r0", 64'({req1_ready, req0_ready}), 64'b01);
        req0_valid = 1'b0; req1_valid = 1'b1; #1;
        check("rst_ready_r1", 64'({req1_ready, req0_ready}), 64'b10);
        req0_valid = 1'b1; #1;
`ifdef SM4_SBOX_SCHED_RR_EN
        check("rst_ready_tie", 64'({req1_ready, req0_ready}), 64'b01);
`else
        check("rst_ready_tie", 64'({req1_ready, req0_ready}), 64'b10);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Single words from each requester.
        rsp_ready = 1'b1;
        send(vt[0].id, vt[0].data, vt[0].exp);
        drain();
        send(vt[1].id, vt[1].data, vt[1].exp);
        drain();

        // Backpressure: response and ids frozen, nobody accepted.
        rsp_ready = 1'b0;
        send(1'b0, 32'hdeadbeef, tau(32'hdeadbeef));
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        check("bp_reach_done", 64'(got), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 32'h1; req1_data = 32'h2;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_data", 64'(rsp_data), 64'(tau(32'hdeadbeef)));
            check("bp_id", 64'(rsp_id), 64'd0);
            check("bp_ready", 64'({req1_ready, req0_ready}), 64'b00);
            check("bp_valid", 64'(rsp_valid), 64'd1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_idle_valid", 64'(rsp_valid), 64'd0);
        drain();

        // Back-to-back contention from reset.
        pulse_reset();
        rsp_ready = 1'b1;
        d0 = 32'h01234567; d1 = 32'h89abcdef; prev_acc = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = d0; req1_data = d1;
        for (int wn = 0; wn < 4; wn++) begin
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin got = 1'b1; break; end
            end
            check("cont_accept", 64'(got), 64'd1);
`ifdef SM4_SBOX_SCHED_RR_EN
            exp_win = ~lg;
`else
            exp_win = 1'b1;
`endif
            check("cont_grant", 64'({req1_ready, req0_ready}), exp_win ? 64'b10 : 64'b01);
            q.push_back('{id: exp_win, data: tau(exp_win ? d1 : d0), acc: cyc + 1});
            if (wn > 0) check("cont_spacing", 64'(cyc + 1 - prev_acc), 64'd6);
            prev_acc = cyc + 1;
            lg = exp_win;
            @(posedge clk); #1;
            d0 = d0 + 32'h11111111; d1 = d1 ^ 32'h5a5a5a5a;
            req0_data = d0; req1_data = d1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Reset in the middle of SUB discards the word immediately.
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_data = 32'h12345678;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req1_ready) begin got = 1'b1; break; end
        end
        check("mid_accept", 64'(got), 64'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_rsp_data", 64'(rsp_data), 64'd0);
        check("mid_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        lg = 1'b1;
        send(vt[2].id, vt[2].data, vt[2].exp);
        drain();

        // S-box sweep through the vector table.
        for (int i = 3; i < 67; i++) send(vt[i].id, vt[i].data, vt[i].exp);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
